// File: rtl/if_id_inst_queue_pkg.sv
// Shared RV32 decode constants: immediate-type codes, base opcodes, NOP word
// and the per-entry layout of the IF/ID instruction queue.
package if_id_inst_queue_pkg;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    imm_type_e   imm_type;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/if_id_inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID queue; the queue
// itself takes the slave view, the fetch/decode environment the master view.
interface if_id_inst_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     flush;
  logic                     fetch_valid;
  logic                     fetch_ready;
  logic [31:0]              fetch_pc;
  logic [31:0]              fetch_inst;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [31:0]              dec_pc;
  logic [31:0]              dec_inst;
  logic [2:0]               dec_imm_type;
  logic                     dec_illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, fetch_valid, fetch_pc, fetch_inst, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_inst, dec_imm_type, dec_illegal, count
  );

  modport slave (
    input  flush, fetch_valid, fetch_pc, fetch_inst, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_inst, dec_imm_type, dec_illegal, count
  );
endinterface

// File: rtl/imm_type_decoder.sv
// Opcode -> immediate-format classifier, purely combinational (0 cycles, no handshake).
// Unknown opcodes fall back to RTYPE and raise illegal for the exception unit.
module imm_type_decoder
  import if_id_inst_queue_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_type_e  imm_type,
  output logic       illegal
);

  always_comb begin
    imm_type = RTYPE;
    illegal  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:                         imm_type = UTYPE;
      OPC_JAL:                                    imm_type = JTYPE;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: imm_type = ITYPE;
      OPC_STORE:                                  imm_type = STYPE;
      OPC_BRANCH:                                 imm_type = BTYPE;
      OPC_OP:                                     imm_type = RTYPE;
      default:                                    illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_inst_queue.sv
// IF->ID instruction queue with opcode pre-decode; 1-cycle push-to-head latency,
// fetch_ready drops only when full (a same-cycle pop does not free a slot).
module if_id_inst_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = if_id_inst_queue_pkg::NOP_INST
) (
  input  logic               clk,
  input  logic               rst,
  if_id_inst_queue_if.slave  q
);
  import if_id_inst_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          head;
  entry_t          new_entry;
  imm_type_e       fetch_type;
  logic            fetch_illegal;
  logic            push;
  logic            pop;
  logic            not_empty;

  imm_type_decoder u_imm_type_decoder (
    .opcode   (q.fetch_inst[6:0]),
    .imm_type (fetch_type),
    .illegal  (fetch_illegal)
  );

  assign new_entry = '{pc: q.fetch_pc, inst: q.fetch_inst,
                       imm_type: fetch_type, illegal: fetch_illegal};

  assign not_empty     = (count != '0);
  assign q.fetch_ready = (count != FULL);
  assign q.dec_valid   = not_empty;
  assign push          = q.fetch_valid & q.fetch_ready & ~q.flush;
  assign pop           = not_empty & q.dec_ready & ~q.flush;

  // Head is read straight from storage, so there is never a fetch->decode path.
  assign head           = mem[rd_ptr];
  assign q.dec_pc       = head.pc;
  assign q.dec_inst     = not_empty ? head.inst : NOP_INST;
  assign q.dec_imm_type = not_empty ? head.imm_type : ITYPE;
  assign q.dec_illegal  = not_empty & head.illegal;
  assign q.count        = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed and scoreboard-checked stimulus for the IF/ID instruction queue.
module tb_if_id_inst_queue;
  import if_id_inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  if_id_inst_queue_if #(.DEPTH(4)) q ();

  if_id_inst_queue #(.DEPTH(4), .NOP_INST(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    q.flush       = 1'b0;
    q.fetch_valid = 1'b0;
    q.dec_ready   = 1'b0;
    q.fetch_pc    = '0;
    q.fetch_inst  = '0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    q.fetch_valid = 1'b1;
    q.fetch_pc    = pc;
    q.fetch_inst  = inst;
    tick();
    q.fetch_valid = 1'b0;
  endtask

  logic [31:0] imm_inst [6];
  logic [2:0]  imm_exp  [6];
  logic        ill_exp  [6];
  logic [31:0] pop_pcs  [5];
  logic [63:0] sb [$];

  initial begin
    logic [31:0] pc_seq;
    logic [31:0] inst_seq;
    logic        fv, dr, fl;

    imm_inst = '{32'h008000EF, 32'h00112623, 32'hFE000EE3, 32'h000010B7, 32'h00000000, 32'h00002083};
    imm_exp  = '{3'd5, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    ill_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pop_pcs  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst_count", 32'(q.count), 32'd0);
    check("rst_dec_valid", 32'(q.dec_valid), 32'd0);
    check("rst_dec_inst", q.dec_inst, 32'h00000013);
    check("rst_imm_type", 32'(q.dec_imm_type), 32'd1);
    check("rst_illegal", 32'(q.dec_illegal), 32'd0);
    check("rst_fetch_ready", 32'(q.fetch_ready), 32'd1);
    check("rst_dec_pc", q.dec_pc, 32'd0);
    rst = 1'b0;

    // Mid-cycle reset with two entries queued.
    push_one(32'h50, 32'h00100093);
    push_one(32'h54, 32'h00200093);
    check("pre_rst_count", 32'(q.count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_count", 32'(q.count), 32'd0);
    check("midrst_dec_valid", 32'(q.dec_valid), 32'd0);
    check("midrst_dec_inst", q.dec_inst, 32'h00000013);
    check("midrst_fetch_ready", 32'(q.fetch_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Fill to DEPTH with decode stalled, then hold a 5th fetch off.
    for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'h00000093 | 32'(i << 20));
    check("full_count", 32'(q.count), 32'd4);
    check("full_fetch_ready", 32'(q.fetch_ready), 32'd0);
    check("full_head_inst", q.dec_inst, 32'h00000093);
    q.fetch_valid = 1'b1;
    q.fetch_pc    = 32'h10;
    q.fetch_inst  = 32'h00400093;
    tick();
    check("full_holdoff_count", 32'(q.count), 32'd4);
    check("full_holdoff_head", q.dec_pc, 32'h0);
    q.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_pc", q.dec_pc, pop_pcs[i]);
      if (i == 0) check("drain_no_passthru", 32'(q.fetch_ready), 32'd0);
      tick();
      if (i == 1) q.fetch_valid = 1'b0;
    end
    check("drain_count", 32'(q.count), 32'd0);
    check("drain_dec_valid", 32'(q.dec_valid), 32'd0);
    check("drain_dec_inst", q.dec_inst, 32'h00000013);
    q.dec_ready = 1'b0;

    // Steady push+pop at count=2 across pointer wrap.
    push_one(32'h100, 32'h00000013);
    push_one(32'h104, 32'h00000013);
    q.dec_ready   = 1'b1;
    q.fetch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q.fetch_pc   = 32'h108 + 32'(4 * i);
      q.fetch_inst = 32'h00000013;
      check("pp_head_pc", q.dec_pc, 32'h100 + 32'(4 * i));
      tick();
      check("pp_count", 32'(q.count), 32'd2);
    end
    q.fetch_valid = 1'b0;
    check("pp_tail0", q.dec_pc, 32'h128);
    tick();
    check("pp_tail1", q.dec_pc, 32'h12C);
    tick();
    check("pp_empty", 32'(q.count), 32'd0);
    q.dec_ready = 1'b0;

    // Immediate-type pre-decode.
    for (int i = 0; i < 6; i++) begin
      push_one(32'h200 + 32'(4 * i), imm_inst[i]);
      check("imm_valid", 32'(q.dec_valid), 32'd1);
      check("imm_type", 32'(q.dec_imm_type), 32'(imm_exp[i]));
      check("imm_illegal", 32'(q.dec_illegal), 32'(ill_exp[i]));
      check("imm_inst", q.dec_inst, imm_inst[i]);
      q.dec_ready = 1'b1;
      tick();
      q.dec_ready = 1'b0;
    end

    // Flush with count=3 plus concurrent push and pop.
    push_one(32'h300, 32'h00000013);
    push_one(32'h304, 32'h00000013);
    push_one(32'h308, 32'h00000013);
    check("preflush_count", 32'(q.count), 32'd3);
    q.flush       = 1'b1;
    q.fetch_valid = 1'b1;
    q.fetch_pc    = 32'h3FC;
    q.fetch_inst  = 32'hDEADBEEF;
    q.dec_ready   = 1'b1;
    tick();
    idle_inputs();
    check("flush_count", 32'(q.count), 32'd0);
    check("flush_dec_valid", 32'(q.dec_valid), 32'd0);
    check("flush_dec_inst", q.dec_inst, 32'h00000013);
    tick();
    check("flush_still_empty", q.dec_inst, 32'h00000013);
    push_one(32'h400, 32'h00000033);
    check("postflush_pc", q.dec_pc, 32'h400);
    check("postflush_count", 32'(q.count), 32'd1);
    q.dec_ready = 1'b1;
    tick();
    q.dec_ready = 1'b0;

    // Random traffic against a queue scoreboard.
    pc_seq   = 32'h1000;
    inst_seq = $urandom;
    for (int c = 0; c < 10000; c++) begin
      fv = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 2);
      q.fetch_valid = fv;
      q.dec_ready   = dr;
      q.flush       = fl;
      q.fetch_pc    = pc_seq;
      q.fetch_inst  = inst_seq;
      check("rnd_count", 32'(q.count), 32'(sb.size()));
      check("rnd_valid", 32'(q.dec_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("rnd_pc", q.dec_pc, sb[0][63:32]);
        check("rnd_inst", q.dec_inst, sb[0][31:0]);
      end else begin
        check("rnd_nop", q.dec_inst, 32'h00000013);
      end
      if (fl) begin
        sb.delete();
      end else begin
        if (dr && sb.size() != 0) void'(sb.pop_front());
        if (fv && (sb.size() + ((dr && sb.size() != 0) ? 1 : 0)) != 4) begin
          sb.push_back({pc_seq, inst_seq});
          pc_seq   = pc_seq + 32'd4;
          inst_seq = $urandom;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
